// File: rtl/tff_bank_if.sv
// tff_bank_if: control/status bundle for one tff_bank.
//   master: drives en, mode, t, d, up; observes q, q_n, chg, tc
//   slave : the bank itself
interface tff_bank_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] d;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] chg;
  logic             tc;

  modport master (output en, mode, t, d, up, input  q, q_n, chg, tc);
  modport slave  (input  en, mode, t, d, up, output q, q_n, chg, tc);
endinterface

// File: rtl/tff_bank.sv
// tff_bank: WIDTH T flip-flops with hold / masked toggle / load / up-down count.
//   clk      : clock, all state updates on posedge
//   rst      : asynchronous active-high reset (q=RESET_VAL, chg=0, tc=0)
//   bus.en   : clock enable; 0 holds q and clears chg/tc on the edge
//   bus.mode : 00 hold, 01 toggle by t, 10 load d, 11 count
//   bus.t/d  : toggle mask / load data
//   bus.up   : count direction (1 up, 0 down)
//   bus.q    : state, bus.q_n = ~q (combinational)
//   bus.chg  : bits that flipped on the last edge (registered)
//   bus.tc   : count sitting at terminal value (registered)
//
// Every mode is reduced to a per-bit toggle vector, so the storage is a plain
// array of T cells; load becomes "toggle the bits where q differs from d".

module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t_i,
  output logic q_o
);
  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q_q <= RST_VAL;
    else if (t_i) q_q <= ~q_q;
  end

  assign q_o = q_q;
endmodule

module tff_bank #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               COUNT_WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  tff_bank_if.slave    bus
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tog_d;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] ones_pre;   // ones_pre[i]  = &q[i-1:0], bit 0 is vacuously 1
  logic [WIDTH-1:0] zeros_pre;  // zeros_pre[i] = ~|q[i-1:0]
  logic             at_term;
  logic [WIDTH-1:0] chg_q;
  logic             tc_q;
  logic             tc_d;

  // Ripple prefix chains: the classic chained-T counter carry/borrow.
  assign ones_pre[0]  = 1'b1;
  assign zeros_pre[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_pre
    assign ones_pre[i]  = ones_pre[i-1]  &  q[i-1];
    assign zeros_pre[i] = zeros_pre[i-1] & ~q[i-1];
  end

  // TERM tracks the current direction, so up may change on any cycle.
  assign at_term = bus.up ? (ones_pre[WIDTH-1]  &  q[WIDTH-1])
                          : (zeros_pre[WIDTH-1] & ~q[WIDTH-1]);

  always_comb begin
    tog_d = '0;
    if (bus.en) begin
      unique case (bus.mode)
        2'b00: tog_d = '0;
        2'b01: tog_d = bus.t;
        2'b10: tog_d = q ^ bus.d;
        2'b11: begin
          // At TERM the prefix is all ones, so every bit toggles: that is
          // the wrap. Saturation simply suppresses the toggle.
          if (!COUNT_WRAP && at_term) tog_d = '0;
          else                        tog_d = bus.up ? ones_pre : zeros_pre;
        end
        default: tog_d = '0;
      endcase
    end
  end

  assign q_next = q ^ tog_d;
  assign tc_d   = bus.en && (bus.mode == 2'b11) && (q_next == {WIDTH{bus.up}});

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
      .clk (clk),
      .rst (rst),
      .t_i (tog_d[i]),
      .q_o (q[i])
    );
  end

  // q ^ q_next is exactly the toggle vector; it is zero whenever en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      chg_q <= tog_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.q   = q;
  assign bus.q_n = ~q;
  assign bus.chg = chg_q;
  assign bus.tc  = tc_q;
endmodule

// File: tb/tb_tff_bank.sv
// Bench for tff_bank at WIDTH=4: one wrapping and one saturating instance.
module tb_tff_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tff_bank_if #(.WIDTH(4)) bw ();
  tff_bank_if #(.WIDTH(4)) bs ();

  tff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .COUNT_WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .bus(bw.slave));
  tff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .COUNT_WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .bus(bs.slave));

  typedef struct {
    int         id;
    bit         sel;   // 0: wrap instance, 1: saturating instance
    logic [3:0] q;
    logic [3:0] chg;
    logic       tc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vid    = 0;

  task automatic cmp(input int id, input bit sel, input logic [3:0] eq,
                     input logic [3:0] ec, input logic et);
    logic [3:0] aq, aqn, ac;
    logic       at;
    if (sel) begin aq = bs.q; aqn = bs.q_n; ac = bs.chg; at = bs.tc; end
    else     begin aq = bw.q; aqn = bw.q_n; ac = bw.chg; at = bw.tc; end
    n_vec++;
    if ({aq, aqn, ac, at} !== {eq, ~eq, ec, et}) begin
      n_miss++;
      $display("FAIL vec%0d dut%0d: got q=%b q_n=%b chg=%b tc=%b, want q=%b q_n=%b chg=%b tc=%b",
               id, sel, aq, aqn, ac, at, eq, ~eq, ec, et);
    end
  endtask

  // Monitor: outputs are valid every cycle, so every pending expectation is
  // checked at the negedge following the edge it targets.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      cmp(e.id, e.sel, e.q, e.chg, e.tc);
    end
  end

  // Drive one edge's worth of stimulus onto the selected instance (the other
  // is disabled) and queue what must appear after that edge.
  task automatic step(input bit sel, input logic en, input logic [1:0] mode,
                      input logic [3:0] t, input logic [3:0] d, input logic up,
                      input logic [3:0] eq, input logic [3:0] ec, input logic et);
    exp_t e;
    @(negedge clk);
    #1;
    bw.en = 1'b0; bs.en = 1'b0;
    if (sel) begin bs.en = en; bs.mode = mode; bs.t = t; bs.d = d; bs.up = up; end
    else     begin bw.en = en; bw.mode = mode; bw.t = t; bw.d = d; bw.up = up; end
    e.id = vid; e.sel = sel; e.q = eq; e.chg = ec; e.tc = et;
    vid++;
    sbq.push_back(e);
  endtask

  initial begin
    bw.en = 1'b0; bw.mode = 2'b00; bw.t = '0; bw.d = '0; bw.up = 1'b1;
    bs.en = 1'b0; bs.mode = 2'b00; bs.t = '0; bs.d = '0; bs.up = 1'b1;

    // 1. async reset with no clock edge, then en=0 holds everything
    #2 rst = 1'b1;
    #1;
    cmp(1000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    cmp(1001, 1'b1, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    repeat (5) step(1'b0, 1'b0, 2'b01, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // 2. masked toggle
    step(1'b0, 1'b1, 2'b01, 4'b0101, 4'b0000, 1'b1, 4'b0101, 4'b0101, 1'b0);
    step(1'b0, 1'b1, 2'b01, 4'b0101, 4'b0000, 1'b1, 4'b0000, 4'b0101, 1'b0);
    step(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // 3. load then hold
    step(1'b0, 1'b1, 2'b10, 4'b0000, 4'b1010, 1'b1, 4'b1010, 4'b1010, 1'b0);
    repeat (3) step(1'b0, 1'b1, 2'b00, 4'b1111, 4'b0101, 1'b1, 4'b1010, 4'b0000, 1'b0);

    // 4. wrap counter up from 0000
    step(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1010, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] kq;
      kq = 4'(k);
      step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, kq, kq ^ (kq - 4'd1), (k == 15));
    end
    step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0);
    // down from 0000 wraps to 1111 (not TERM for down)
    step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0);

    // 5. saturating counter
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] kq;
      kq = 4'(k);
      step(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, kq, kq ^ (kq - 4'd1), (k == 15));
    end
    repeat (3) step(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1);
    for (int k = 14; k >= 0; k--) begin
      logic [3:0] kq;
      kq = 4'(k);
      step(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b0, kq, kq ^ (kq + 4'd1), (k == 0));
    end
    step(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    // en=0 clears tc while saturated
    step(1'b1, 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

    // 6. reset mid-count
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] kq;
      kq = 4'(k);
      step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, kq, kq ^ (kq - 4'd1), 1'b0);
    end
    @(negedge clk);
    #2 rst = 1'b1; bw.en = 1'b0;
    #1;
    cmp(1002, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0);

    // drain
    repeat (2) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
